// File: rtl/aes128_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_iter
//   Iterative AES-128 encryption engine, one round per clock.
//   Initial AddRoundKey on load, rounds 1-9 through aes_round, round 10
//   through a local SubBytes/ShiftRows path that shares the key expansion
//   of aes_round (driven by rc).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   plaintext/key presented
//   in_ready   out  engine can accept a block
//   plaintext  in   [127:0] input block, byte 0 at [127:120]
//   key        in   [127:0] cipher key, same byte order
//   out_valid  out  ciphertext valid
//   out_ready  in   consumer accepts ciphertext
//   ciphertext out  [127:0] result, byte 0 at [127:120]
//   busy       out  high in ROUND or FINAL
//
// Parameter CLEAR_ON_DONE: 1 clears state/key/rc and ciphertext on the
//   output handshake, 0 holds them.
// Optional macro AES_BACK_TO_BACK_EN: accept a new block on the same edge
//   as the output handshake (in_ready also high in DONE when out_ready).
// ---------------------------------------------------------------------------

// S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p, b;
      p = '0;
      b = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ b;
         b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   localparam logic [7:0] INV_EXP = 8'hfe;
   logic [7:0] inv, base;

   always_comb begin
      inv  = 8'h01;
      base = a;
      for (int i = 0; i < 8; i++) begin
         if (INV_EXP[i]) inv = gmul(inv, base);
         base = gmul(base, base);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_sub_bytes (
   input  logic [127:0] d,
   output logic [127:0] q
);
   for (genvar i = 0; i < 16; i++) begin : g_sb
      aes_sbox u_sbox (.a(d[8*i +: 8]), .s(q[8*i +: 8]));
   end
endmodule

// Byte index i = row + 4*col lives at [127-8i -: 8]; row r rotates left by r.
module aes_shift_rows (
   input  logic [127:0] d,
   output logic [127:0] q
);
   always_comb begin
      q = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            q[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c+r)%4)) -: 8];
   end
endmodule

// Full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) plus the
// on-the-fly key expansion step selected by rc.
module aes_round (
   input  logic [3:0]   rc,
   input  logic [127:0] state_in,
   input  logic [127:0] key_in,
   output logic [127:0] rndout,
   output logic [127:0] key_out
);
   logic [7:0]   rcon;
   logic [31:0]  rot_w, sub_w, temp;
   logic [127:0] sb, sr, mc;

   always_comb begin
      case (rc)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign rot_w = {key_in[23:0], key_in[31:24]};
   for (genvar i = 0; i < 4; i++) begin : g_ks
      aes_sbox u_sbox (.a(rot_w[8*i +: 8]), .s(sub_w[8*i +: 8]));
   end
   assign temp = sub_w ^ {rcon, 24'h0};

   always_comb begin
      key_out[127:96] = key_in[127:96] ^ temp;
      key_out[95:64]  = key_in[95:64]  ^ key_out[127:96];
      key_out[63:32]  = key_in[63:32]  ^ key_out[95:64];
      key_out[31:0]   = key_in[31:0]   ^ key_out[63:32];
   end

   aes_sub_bytes  u_sb (.d(state_in), .q(sb));
   aes_shift_rows u_sr (.d(sb), .q(sr));

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = sr[127-32*c -: 8];
         a1 = sr[119-32*c -: 8];
         a2 = sr[111-32*c -: 8];
         a3 = sr[103-32*c -: 8];
         mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
   end

   assign rndout = mc ^ key_out;
endmodule

module aes128_encrypt_iter #(
   parameter bit CLEAR_ON_DONE = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
   state_t cur, nxt;

   logic [127:0] state_reg, key_reg, rnd_out, key_out, fsb, fsr;
   logic [3:0]   rc;
   logic         load;

   aes_round u_round (
      .rc(rc), .state_in(state_reg), .key_in(key_reg),
      .rndout(rnd_out), .key_out(key_out)
   );

   // Final round: no MixColumns; round key 10 comes from the shared expansion.
   aes_sub_bytes  u_fsb (.d(state_reg), .q(fsb));
   aes_shift_rows u_fsr (.d(fsb), .q(fsr));

   assign load = in_valid && in_ready;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= IDLE;
      else        cur <= nxt;
   end

   // next state
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:  if (in_valid) nxt = ROUND;
         ROUND: if (rc == 4'd9) nxt = FINAL;
         FINAL: nxt = DONE;
         DONE: begin
            if (out_ready) begin
`ifdef AES_BACK_TO_BACK_EN
               nxt = in_valid ? ROUND : IDLE;
`else
               nxt = IDLE;
`endif
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      busy     = (cur == ROUND) || (cur == FINAL);
`ifdef AES_BACK_TO_BACK_EN
      in_ready = (cur == IDLE) || ((cur == DONE) && out_ready);
`else
      in_ready = (cur == IDLE);
`endif
   end

   // datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= '0;
         key_reg    <= '0;
         rc         <= '0;
         ciphertext <= '0;
         out_valid  <= 1'b0;
      end else begin
         case (cur)
            ROUND: begin
               state_reg <= rnd_out;
               key_reg   <= key_out;
               rc        <= rc + 4'd1;
            end
            FINAL: begin
               ciphertext <= fsr ^ key_out;
               out_valid  <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (CLEAR_ON_DONE) ciphertext <= '0;
                  // a block loading on this edge keeps its fresh state/key
                  if (CLEAR_ON_DONE && !load) begin
                     state_reg <= '0;
                     key_reg   <= '0;
                     rc        <= '0;
                  end
               end
            end
            default: ;
         endcase
         if (load) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            rc        <= 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
module tb_aes128_encrypt_iter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, out_ready;
   logic [127:0] plaintext, key;
   logic         in_ready, out_valid, busy;
   logic [127:0] ct0;
   logic         in_ready1, out_valid1, busy1;
   logic [127:0] ct1;

   int errors = 0;
   int checks = 0;
   logic [127:0] sb[$];
   logic [127:0] last_exp;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   // dut0 clears on done, dut1 holds; both see identical stimulus
   aes128_encrypt_iter #(.CLEAR_ON_DONE(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .key(key), .out_valid(out_valid),
      .out_ready(out_ready), .ciphertext(ct0), .busy(busy));
   aes128_encrypt_iter #(.CLEAR_ON_DONE(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .plaintext(plaintext), .key(key), .out_valid(out_valid1),
      .out_ready(out_ready), .ciphertext(ct1), .busy(busy1));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
      int n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      chk("in_ready_wait", in_ready, 1'b1);
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      tick();
      sb.push_back(exp);
      in_valid  = 1'b0;
   endtask

   task automatic wait_out(input bit disturb);
      int lat = 0;
      bit busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (!busy || in_ready) busy_ok = 1'b0;
         if (disturb) begin
            in_valid  = 1'($urandom_range(0, 1));
            plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            key       = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", 128'(lat), 128'd10);
      chk("busy_during", busy_ok, 1'b1);
      chk("busy_done", busy, 1'b0);
      chk("sb_nonempty", (sb.size() > 0), 1'b1);
      last_exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("ct_clear_dut", ct0, last_exp);
      chk("ct_hold_dut", ct1, last_exp);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_out_valid", out_valid, 1'b0);
      chk("hs_in_ready", in_ready, 1'b1);
      chk("hs_ct_cleared", ct0, 128'h0);
      chk("hs_ct_held", ct1, last_exp);
   endtask

   initial begin
      bit hold_ok;
      int lat;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      plaintext = '0; key = '0;
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_ct", ct0, 128'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // FIPS-197 C.1
      send(C1_PT, C1_KEY, C1_CT);
      wait_out(1'b0);
      handshake();

      // App. B with busy-time disturbance and a long out_ready stall
      send(B_PT, B_KEY, B_CT);
      wait_out(1'b1);
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         tick();
         if (ct0 !== B_CT || ct1 !== B_CT || in_ready || !out_valid) hold_ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("stall_stable", hold_ok, 1'b1);
      handshake();

      // reset at rc=5: after the accept edge rc=1, four more edges give rc=5
      send(C1_PT, C1_KEY, C1_CT);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_ct", ct0, 128'h0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      sb.delete();
      tick();
      rst_n = 1'b1;
      tick();
      send(C1_PT, C1_KEY, C1_CT);
      wait_out(1'b0);
      handshake();

`ifdef AES_BACK_TO_BACK_EN
      out_ready = 1'b1;
      send(C1_PT, C1_KEY, C1_CT);
      in_valid  = 1'b1;
      plaintext = B_PT;
      key       = B_KEY;
      lat = 0;
      while (!out_valid && lat < 40) begin tick(); lat++; end
      chk("b2b_lat1", 128'(lat), 128'd10);
      chk("b2b_ct1", ct0, (sb.size() > 0) ? sb.pop_front() : 'x);
      tick();   // handshake of block 1, acceptance of block 2
      sb.push_back(B_CT);
      in_valid = 1'b0;
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_ct_cleared", ct0, 128'h0);
      lat = 0;
      while (!out_valid && lat < 40) begin tick(); lat++; end
      chk("b2b_gap", 128'(lat + 1), 128'd11);
      last_exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("b2b_ct2", ct0, last_exp);
      chk("b2b_ct2_hold", ct1, last_exp);
      tick();
      out_ready = 1'b0;
      chk("b2b_idle", in_ready, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
Iterative AES-128 encryption engine that sequences the existing single-round datapath over 10 rounds, one round per clock.
- Performs the initial AddRoundKey on load.
- Rounds 1-9 use the round datapath. Round 10 is a local final-round path with no MixColumns.
- Uses a valid/ready handshake on both sides.
- Sits between the block-level input buffer and the ciphertext consumer.

Parameters:
CLEAR_ON_DONE, 1, when 1 zero the state/key registers and the ciphertext register on output handshake; when 0 they hold their values.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext/key presented
in_ready  output  1  engine can accept a block
plaintext  input  128  input block, byte 0 at [127:120]
key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext valid
out_ready  input  1  consumer accepts ciphertext
ciphertext  output  128  result, byte 0 at [127:120]
busy  output  1  high in ROUND or FINAL

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - state_reg=0, key_reg=0, rc=0, ciphertext=0.
  - out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge E0: state_reg<=plaintext^key, key_reg<=key, rc<=1, go to ROUND.
- ROUND (rc 1..9), each edge:
  - state_reg<=round(rc,state_reg,key_reg).rndout.
  - key_reg<=key_out.
  - rc<=rc+1.
  - When the edge applies rc=9, go to FINAL with rc=10.
- FINAL (rc=10), one edge:
  - Round key is taken from the key-expansion output at rc=10 (Rcon 0x36).
  - ciphertext<=shift_rows(sub_byte(state_reg)) ^ key_out(rc=10).
  - out_valid<=1, go to DONE.
  - The final round instantiates its own sub_byte and shift_rows. Key expansion is shared with the round instance, driven by rc.
- DONE:
  - out_valid=1 and ciphertext are held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE.
  - If CLEAR_ON_DONE=1, also clear ciphertext, state_reg, key_reg and rc to 0.
- Latency: accept at E0; ciphertext valid after E10, i.e. 10 cycles of processing; throughput 1 block per 11 cycles (12 with the IDLE cycle).
- in_ready=0 in ROUND, FINAL and DONE. in_valid in those states is ignored; the input is not sampled.
- plaintext and key need only be stable at the accepting edge.
- rc width is 4; it never exceeds 10. rc is not used in IDLE or DONE.
- Reset mid-operation: everything returns to the reset values immediately. No partial output; out_valid never glitches high.
- out_ready while out_valid=0 has no effect.

Optional Feature:
AES_BACK_TO_BACK_EN
- Defined:
  - in_ready = IDLE || (DONE && out_ready).
  - In DONE with out_ready&&in_valid on the same edge: output completes and the new block loads as in IDLE (state_reg, key_reg, rc=1), going straight to ROUND.
  - out_valid<=0 on that edge.
  - Throughput becomes 1 block per 11 cycles.
  - CLEAR_ON_DONE clearing applies only to the ciphertext register in this case.
- Undefined:
  - in_ready is IDLE-only.
  - DONE always returns to IDLE first.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises exactly 10 cycles after acceptance, busy high for those 10 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Hold out_ready=0 for 20 cycles; ciphertext must be stable and in_ready must stay 0.
- Change plaintext/key and pulse in_valid while busy -> ignored; the result still equals the original vector.
- Assert rst_n=0 at rc=5 -> all outputs 0 and in_ready=1 immediately. A new C.1 encryption after reset gives the correct result.
- CLEAR_ON_DONE=1: after the output handshake, ciphertext reads 0. CLEAR_ON_DONE=0: ciphertext keeps its value.
- With AES_BACK_TO_BACK_EN: two vectors back-to-back with out_ready=1 and in_valid=1 continuously -> second out_valid rises 11 cycles after the first, both results correct.
